ysyx_20020207_axi_sram_slave: RTL and testbench

YSYX_20020207_AXI_SRAM_SLAVE -- requirements
Module: ysyx_20020207_axi_sram_slave

---
 rtl/ysyx_20020207_axi_sram_slave_pkg.sv | 35 +++
 rtl/ysyx_20020207_sram_array.sv | 39 +++
 rtl/ysyx_20020207_axi_sram_slave.sv | 240 ++++++++++++++++++++++++
 tb/tb_ysyx_20020207_axi_sram_slave.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_20020207_axi_sram_slave_pkg.sv
// Shared types and helpers for the AXI-Lite SRAM slave.
package ysyx_20020207_axi_sram_slave_pkg;

    // Controller FSM: one outstanding transaction, read or write.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_DATA = 3'd3,
        WR_WAIT = 3'd4,
        WR_RESP = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Width of the latency down-counter (supports latencies up to 65536).
    localparam int LAT_W = 16;

    // True when addr falls inside [base, base + 4*2^abits).
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int          abits);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (off < (33'd1 << (abits + 2)));
    endfunction

    // Word offset of addr relative to base; byte-offset bits are dropped.
    function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/ysyx_20020207_sram_array.sv
// Word-organised storage: synchronous byte-enable write, registered read.
// Contents are deliberately not reset.
module ysyx_20020207_sram_array #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [31:0]          i_wdata,
    input  logic [3:0]           i_wstrb,
    input  logic                 i_re,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [31:0]          o_rdata
);

    logic [31:0] r_mem [0:(1 << ADDR_BITS) - 1];
    logic [31:0] r_rdata;

    // Write only the byte lanes selected by the strobe.
    always_ff @(posedge clock) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Capture the addressed word; output holds until the next read.
    always_ff @(posedge clock) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ysyx_20020207_axi_sram_slave.sv
// Single-beat AXI-Lite slave in front of a word SRAM with configurable
// read/write latency. All outputs come from registers.
module ysyx_20020207_axi_sram_slave
    import ysyx_20020207_axi_sram_slave_pkg::*;
#(
    parameter logic [31:0] BASE      = 32'h8000_0000,
    parameter int          ADDR_BITS = 10,
    parameter int          RD_LAT    = 1,
    parameter int          WR_LAT    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp
);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [LAT_W-1:0]       r_lat_cnt;
    logic                   w_lat_zero;

    logic                   r_arready;
    logic                   r_awready;
    logic                   r_wready;
    logic                   r_rvalid;
    logic                   r_bvalid;
    logic [31:0]            r_rdata;
    logic [1:0]             r_rresp;
    logic [1:0]             r_bresp;

    logic                   r_rd_ok;
    logic                   r_wr_ok;
    logic [ADDR_BITS-1:0]   r_wr_idx;
    logic [31:0]            r_wdata;
    logic [3:0]             r_wstrb;

    logic                   w_ar_hs;
    logic                   w_aw_hs;
    logic                   w_w_take;
    logic                   w_ar_ok;
    logic                   w_aw_ok;
    logic [ADDR_BITS-1:0]   w_ar_idx;
    logic [ADDR_BITS-1:0]   w_aw_idx;
    logic                   w_mem_we;
    logic [31:0]            w_mem_rdata;

    // Handshakes use the registered readies, so nothing is accepted in the
    // first cycle after reset even though the state is already IDLE.
    assign w_ar_hs  = (r_state == IDLE) && arvalid && r_arready;
    assign w_aw_hs  = (r_state == IDLE) && awvalid && r_awready && !arvalid;
    // A W beat is only consumed together with, or after, its AW; a lone W in
    // IDLE is not stored.
    assign w_w_take = wvalid && r_wready &&
                      (w_aw_hs || (r_state == WR_DATA));

    assign w_ar_ok  = addr_in_range(araddr, BASE, ADDR_BITS);
    assign w_aw_ok  = addr_in_range(awaddr, BASE, ADDR_BITS);
    assign w_ar_idx = ADDR_BITS'(word_offset(araddr, BASE));
    assign w_aw_idx = ADDR_BITS'(word_offset(awaddr, BASE));

    assign w_lat_zero = (r_lat_cnt == {LAT_W{1'b0}});

    // The write commits exactly once, on the edge that leaves WR_WAIT.
    assign w_mem_we = (r_state == WR_WAIT) && w_lat_zero && r_wr_ok && !reset;

    ysyx_20020207_sram_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clock   (clock),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_idx),
        .i_wdata (r_wdata),
        .i_wstrb (r_wstrb),
        .i_re    (w_ar_hs),
        .i_raddr (w_ar_idx),
        .o_rdata (w_mem_rdata)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; reads take priority over writes in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_ar_hs) begin
                    w_state_nxt = RD_WAIT;
                end else if (w_aw_hs) begin
                    if (w_w_take) begin
                        w_state_nxt = WR_WAIT;
                    end else begin
                        w_state_nxt = WR_DATA;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                if (w_lat_zero) begin
                    w_state_nxt = RD_RESP;
                end else begin
                    w_state_nxt = RD_WAIT;
                end
            end
            RD_RESP: begin
                if (rready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RD_RESP;
                end
            end
            WR_DATA: begin
                if (w_w_take) begin
                    w_state_nxt = WR_WAIT;
                end else begin
                    w_state_nxt = WR_DATA;
                end
            end
            WR_WAIT: begin
                if (w_lat_zero) begin
                    w_state_nxt = WR_RESP;
                end else begin
                    w_state_nxt = WR_WAIT;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WR_RESP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Latency counter: loaded on entry to a wait state, counts down to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lat_cnt <= {LAT_W{1'b0}};
        end else if ((r_state != RD_WAIT) && (w_state_nxt == RD_WAIT)) begin
            r_lat_cnt <= LAT_W'(RD_LAT - 1);
        end else if ((r_state != WR_WAIT) && (w_state_nxt == WR_WAIT)) begin
            r_lat_cnt <= LAT_W'(WR_LAT - 1);
        end else if (!w_lat_zero) begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
        end
    end

    // Channel readies and valids registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_arready <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_arready <= (w_state_nxt == IDLE);
            r_awready <= (w_state_nxt == IDLE);
            r_wready  <= (w_state_nxt == IDLE) || (w_state_nxt == WR_DATA);
            r_rvalid  <= (w_state_nxt == RD_RESP);
            r_bvalid  <= (w_state_nxt == WR_RESP);
        end
    end

    // Request capture: range flags, write index, write data and strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ok  <= 1'b0;
            r_wr_ok  <= 1'b0;
            r_wr_idx <= {ADDR_BITS{1'b0}};
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
        end else begin
            if (w_ar_hs) begin
                r_rd_ok <= w_ar_ok;
            end
            if (w_aw_hs) begin
                r_wr_ok  <= w_aw_ok;
                r_wr_idx <= w_aw_idx;
            end
            if (w_w_take) begin
                r_wdata <= wdata;
                r_wstrb <= wstrb;
            end
        end
    end

    // Response payloads; loaded when the wait state ends and held after.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= 32'd0;
            r_rresp <= RESP_OKAY;
            r_bresp <= RESP_OKAY;
        end else begin
            if ((r_state == RD_WAIT) && w_lat_zero) begin
                r_rdata <= r_rd_ok ? w_mem_rdata : 32'd0;
                r_rresp <= r_rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if ((r_state == WR_WAIT) && w_lat_zero) begin
                r_bresp <= r_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign arready = r_arready;
    assign awready = r_awready;
    assign wready  = r_wready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;

endmodule

// File: tb/tb_ysyx_20020207_axi_sram_slave.sv
// Directed bench: vector table on a latency-1 instance plus hand sequences
// for arbitration, reset abort and a latency-3 read instance.
module tb_ysyx_20020207_axi_sram_slave;

    logic clock = 1'b0;
    logic reset = 1'b1;

    // Instance A: RD_LAT = WR_LAT = 1
    logic        arvalid = 1'b0, arready, rvalid, rready = 1'b0;
    logic [31:0] araddr = 32'd0, rdata;
    logic [1:0]  rresp, bresp;
    logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready;
    logic        bvalid, bready = 1'b0;
    logic [31:0] awaddr = 32'd0, wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;

    // Instance B: RD_LAT = 3, WR_LAT = 2
    logic        b_arvalid = 1'b0, b_arready, b_rvalid, b_rready = 1'b0;
    logic [31:0] b_araddr = 32'd0, b_rdata;
    logic [1:0]  b_rresp, b_bresp;
    logic        b_awvalid = 1'b0, b_awready, b_wvalid = 1'b0, b_wready;
    logic        b_bvalid, b_bready = 1'b0;
    logic [31:0] b_awaddr = 32'd0, b_wdata = 32'd0;
    logic [3:0]  b_wstrb = 4'd0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    ysyx_20020207_axi_sram_slave dut (
        .clock(clock), .reset(reset),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    ysyx_20020207_axi_sram_slave #(.RD_LAT(3), .WR_LAT(2)) dut_b (
        .clock(clock), .reset(reset),
        .arvalid(b_arvalid), .arready(b_arready), .araddr(b_araddr),
        .rvalid(b_rvalid), .rready(b_rready), .rdata(b_rdata), .rresp(b_rresp),
        .awvalid(b_awvalid), .awready(b_awready), .awaddr(b_awaddr),
        .wvalid(b_wvalid), .wready(b_wready), .wdata(b_wdata), .wstrb(b_wstrb),
        .bvalid(b_bvalid), .bready(b_bready), .bresp(b_bresp)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    // AW and W together; returns response and edges from handshake to bvalid.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
        int n;
        @(negedge clock);
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
        n = 0;
        while (!(awready && wready) && n < 50) begin @(negedge clock); n++; end
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        lat = 0;
        while (!bvalid && lat < 50) begin @(negedge clock); lat++; end
        resp = bresp;
        @(negedge clock);
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
        int n;
        @(negedge clock);
        arvalid = 1'b1; araddr = a;
        n = 0;
        while (!arready && n < 50) begin @(negedge clock); n++; end
        @(negedge clock);
        arvalid = 1'b0; rready = 1'b1;
        lat = 0;
        while (!rvalid && lat < 50) begin @(negedge clock); lat++; end
        d = rdata; resp = rresp;
        @(negedge clock);
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        logic [31:0] held;

        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
        vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
        vecs[2]  = '{1'b1, 32'h8000_0010, 32'h0000_AA00, 4'h2, 32'h0,         2'b00};
        vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_AAEF, 2'b00};
        vecs[4]  = '{1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, 32'h0,         2'b00};
        vecs[5]  = '{1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b10};
        vecs[6]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h1234_5678, 2'b00};
        vecs[7]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10};
        vecs[8]  = '{1'b1, 32'h8000_0FFF, 32'hA5A5_A5A5, 4'hF, 32'h0,         2'b00};
        vecs[9]  = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'hA5A5_A5A5, 2'b00};
        vecs[10] = '{1'b1, 32'h8000_0013, 32'h1122_3344, 4'h0, 32'h0,         2'b00};
        vecs[11] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_AAEF, 2'b00};
        vecs[12] = '{1'b1, 32'h8000_0010, 32'h01FF_FF02, 4'h9, 32'h0,         2'b00};
        vecs[13] = '{1'b0, 32'h8000_0012, 32'h0,         4'h0, 32'h01AD_AA02, 2'b00};
        vecs[14] = '{1'b1, 32'h8000_0030, 32'h55AA_55AA, 4'hF, 32'h0,         2'b00};
        vecs[15] = '{1'b0, 32'h8000_0030, 32'h0,         4'h0, 32'h55AA_55AA, 2'b00};

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_ready", {29'd0, arready, awready, wready}, 32'd0);
        check("rst_valid", {30'd0, rvalid, bvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", {28'd0, rresp, bresp}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", {29'd0, arready, awready, wready}, 32'h7);

        // Vector table on instance A
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, lat);
                check($sformatf("v%0d_bresp", i), {30'd0, r}, {30'd0, vecs[i].exp_resp});
                check($sformatf("v%0d_blat", i), lat, 32'd1);
            end else begin
                do_read(vecs[i].addr, d, r, lat);
                check($sformatf("v%0d_rdata", i), d, vecs[i].exp_data);
                check($sformatf("v%0d_rresp", i), {30'd0, r}, {30'd0, vecs[i].exp_resp});
                check($sformatf("v%0d_rlat", i), lat, 32'd1);
            end
        end

        // Simultaneous AR and AW: read first, write held off until R completes
        @(negedge clock);
        arvalid = 1'b1; araddr = 32'h8000_0010;
        awvalid = 1'b1; awaddr = 32'h8000_0020; wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        @(negedge clock);
        arvalid = 1'b0;
        check("arb_awready_rdwait", {31'd0, awready}, 32'd0);
        @(negedge clock);
        check("arb_rvalid", {31'd0, rvalid}, 32'd1);
        check("arb_rdata", rdata, 32'h01AD_AA02);
        check("arb_awready_rdresp", {31'd0, awready}, 32'd0);
        @(negedge clock);
        check("arb_awready_hold", {31'd0, awready}, 32'd0);
        rready = 1'b1;
        @(negedge clock);
        rready = 1'b0;
        check("arb_rvalid_done", {31'd0, rvalid}, 32'd0);
        check("arb_awready_free", {31'd0, awready}, 32'd1);
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clock);
        check("arb_bvalid", {31'd0, bvalid}, 32'd1);
        check("arb_bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        @(negedge clock);
        bready = 1'b0;
        do_read(32'h8000_0020, d, r, lat);
        check("arb_wr_data", d, 32'hCAFE_F00D);

        // AW accepted, W delayed 4 cycles, reset during WR_WAIT
        @(negedge clock);
        awvalid = 1'b1; awaddr = 32'h8000_0030;
        @(negedge clock);
        awvalid = 1'b0;
        check("abort_wready_wrdata", {30'd0, awready, wready}, 32'd1);
        repeat (4) @(negedge clock);
        wvalid = 1'b1; wdata = 32'hBADB_AD00; wstrb = 4'hF;
        @(negedge clock);
        wvalid = 1'b0; reset = 1'b1;
        @(negedge clock);
        check("abort_bvalid_rst", {31'd0, bvalid}, 32'd0);
        @(negedge clock);
        reset = 1'b0; bready = 1'b1;
        @(negedge clock);
        check("abort_arready", {31'd0, arready}, 32'd1);
        held = 32'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            held = held | {31'd0, bvalid};
        end
        check("abort_no_bvalid", held, 32'd0);
        bready = 1'b0;
        do_read(32'h8000_0030, d, r, lat);
        check("abort_mem_unchanged", d, 32'h55AA_55AA);

        // Instance B: WR_LAT=2 write, then RD_LAT=3 read with rready low
        @(negedge clock);
        b_awvalid = 1'b1; b_awaddr = 32'h8000_0040; b_wvalid = 1'b1;
        b_wdata = 32'h0BAD_CAFE; b_wstrb = 4'hF;
        @(negedge clock);
        b_awvalid = 1'b0; b_wvalid = 1'b0;
        lat = 0;
        while (!b_bvalid && lat < 50) begin @(negedge clock); lat++; end
        check("b_blat", lat, 32'd2);
        check("b_bresp", {30'd0, b_bresp}, 32'd0);
        b_bready = 1'b1;
        @(negedge clock);
        b_bready = 1'b0;
        @(negedge clock);
        b_arvalid = 1'b1; b_araddr = 32'h8000_0040;
        @(negedge clock);
        b_arvalid = 1'b0;
        lat = 0;
        while (!b_rvalid && lat < 50) begin @(negedge clock); lat++; end
        check("b_rlat", lat, 32'd3);
        check("b_rdata", b_rdata, 32'h0BAD_CAFE);
        held = 32'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (!b_rvalid || (b_rdata !== 32'h0BAD_CAFE)) held++;
        end
        check("b_rdata_stable", held, 32'd0);
        b_rready = 1'b1;
        @(negedge clock);
        b_rready = 1'b0;
        check("b_rvalid_done", {31'd0, b_rvalid}, 32'd0);
        check("b_arready_after", {31'd0, b_arready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
